// File: rtl/regfile_wb_arbiter_if.sv
// Bundles the two writeback request ports, the register-file write port and the
// decode hazard lookup of the writeback arbiter.
interface regfile_wb_arbiter_if #(
   parameter int AW = 5,
   parameter int DW = 32
);
   logic          s0_valid;
   logic          s0_ready;
   logic [AW-1:0] s0_addr;
   logic [DW-1:0] s0_data;
   logic          s1_valid;
   logic          s1_ready;
   logic [AW-1:0] s1_addr;
   logic [DW-1:0] s1_data;
   logic          rf_we;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;
   logic          rf_src;
   logic [AW-1:0] hz_addr;
   logic          hz_pending;

   modport master (
      output s0_valid, s0_addr, s0_data, s1_valid, s1_addr, s1_data, hz_addr,
      input  s0_ready, s1_ready, rf_we, rf_waddr, rf_wdata, rf_src, hz_pending
   );

   modport slave (
      input  s0_valid, s0_addr, s0_data, s1_valid, s1_addr, s1_data, hz_addr,
      output s0_ready, s1_ready, rf_we, rf_waddr, rf_wdata, rf_src, hz_pending
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two writeback sources (s0 ALU, s1 load) share the register file write port through
// per-source FIFOs and a round-robin arbiter; also answers decode's RAW hazard lookup.
module regfile_wb_arbiter_fifo #(
   parameter int DEPTH = 2,
   parameter int AW    = 5,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_valid,
   output logic          push_ready,
   input  logic [AW-1:0] push_addr,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic          not_empty,
   output logic [AW-1:0] head_addr,
   output logic [DW-1:0] head_data,
   input  logic [AW-1:0] hz_addr,
   output logic          hz_hit
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [AW-1:0] mem_addr_q [DEPTH];
   logic [AW-1:0] mem_addr_d [DEPTH];
   logic [DW-1:0] mem_data_q [DEPTH];
   logic [DW-1:0] mem_data_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          push;

   assign push_ready = (cnt_q != FULL);
   assign not_empty  = (cnt_q != '0);
   assign push       = push_valid & push_ready;
   assign head_addr  = mem_addr_q[rd_ptr_q];
   assign head_data  = mem_data_q[rd_ptr_q];

   always_comb begin
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      cnt_d      = cnt_q;
      if (push) begin
         mem_addr_d[wr_ptr_q] = push_addr;
         mem_data_d[wr_ptr_q] = push_data;
         wr_ptr_d             = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
         cnt_d = cnt_q + CW'(1);
      end else if (!push && pop) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   // A slot holds a live entry when its distance from the read pointer is below the count.
   always_comb begin
      logic [PW-1:0] off;
      hz_hit = 1'b0;
      off    = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off = PW'(i) - rd_ptr_q;
         if ((CW'(off) < cnt_q) && (mem_addr_q[PW'(i)] == hz_addr)) begin
            hz_hit = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_addr_q <= '{default: '0};
         mem_data_q <= '{default: '0};
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
      end else begin
         mem_addr_q <= mem_addr_d;
         mem_data_q <= mem_data_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
      end
   end
endmodule

module regfile_wb_arbiter #(
   parameter int DEPTH = 2,
   parameter int AW    = 5,
   parameter int DW    = 32
) (
   input logic                 clk,
   input logic                 rst_n,
   regfile_wb_arbiter_if.slave bus
);
   logic          ne0, ne1, pop0, pop1, hit0, hit1;
   logic [AW-1:0] head_addr0, head_addr1, sel_addr;
   logic [DW-1:0] head_data0, head_data1, sel_data;
   logic          grant_v, grant_s;
   logic          rr_last_q, rr_last_d;
   logic          rf_we_q, rf_we_d;
   logic [AW-1:0] rf_waddr_q, rf_waddr_d;
   logic [DW-1:0] rf_wdata_q, rf_wdata_d;
   logic          rf_src_q, rf_src_d;

   regfile_wb_arbiter_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo0 (
      .clk(clk), .rst_n(rst_n),
      .push_valid(bus.s0_valid), .push_ready(bus.s0_ready),
      .push_addr(bus.s0_addr), .push_data(bus.s0_data),
      .pop(pop0), .not_empty(ne0), .head_addr(head_addr0), .head_data(head_data0),
      .hz_addr(bus.hz_addr), .hz_hit(hit0)
   );

   regfile_wb_arbiter_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo1 (
      .clk(clk), .rst_n(rst_n),
      .push_valid(bus.s1_valid), .push_ready(bus.s1_ready),
      .push_addr(bus.s1_addr), .push_data(bus.s1_data),
      .pop(pop1), .not_empty(ne1), .head_addr(head_addr1), .head_data(head_data1),
      .hz_addr(bus.hz_addr), .hz_hit(hit1)
   );

   always_comb begin
      grant_v    = ne0 | ne1;
      grant_s    = (ne0 & ne1) ? ~rr_last_q : ne1;
      pop0       = grant_v & ~grant_s;
      pop1       = grant_v & grant_s;
      sel_addr   = grant_s ? head_addr1 : head_addr0;
      sel_data   = grant_s ? head_data1 : head_data0;
      rr_last_d  = rr_last_q;
      rf_we_d    = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      rf_src_d   = rf_src_q;
      // r0 writes still take their slot but never strobe the register file.
      if (grant_v) begin
         rr_last_d  = grant_s;
         rf_we_d    = (sel_addr != '0);
         rf_waddr_d = sel_addr;
         rf_wdata_d = sel_data;
         rf_src_d   = grant_s;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_last_q  <= 1'b1;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         rf_src_q   <= 1'b0;
      end else begin
         rr_last_q  <= rr_last_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         rf_src_q   <= rf_src_d;
      end
   end

   assign bus.rf_we      = rf_we_q;
   assign bus.rf_waddr   = rf_waddr_q;
   assign bus.rf_wdata   = rf_wdata_q;
   assign bus.rf_src     = rf_src_q;
   assign bus.hz_pending = (bus.hz_addr != '0) &
                           (hit0 | hit1 | (rf_we_q & (rf_waddr_q == bus.hz_addr)));
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected writes queue per source, a negedge
// monitor retires them as rf_we beats appear; stimulus adds point checks.
module tb_regfile_wb_arbiter;
   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;
   exp_t q0[$];
   exp_t q1[$];
   exp_t mon_e;
   logic [31:0] rf_model [32];

   regfile_wb_arbiter_if #(.AW(5), .DW(32)) bus ();

   regfile_wb_arbiter #(.DEPTH(2), .AW(5), .DW(32)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every write beat must match the oldest expectation of its source.
   always @(negedge clk) begin
      if (rst_n && bus.rf_we === 1'b1) begin
         n_vec++;
         if ((bus.rf_src == 1'b0) ? (q0.size() == 0) : (q1.size() == 0)) begin
            n_err++;
            $display("FAIL unexpected_write actual=src%0d r%0d %h required=none",
                     bus.rf_src, bus.rf_waddr, bus.rf_wdata);
         end else begin
            mon_e = (bus.rf_src == 1'b0) ? q0.pop_front() : q1.pop_front();
            if ({bus.rf_waddr, bus.rf_wdata} !== mon_e) begin
               n_err++;
               $display("FAIL write_src%0d actual=r%0d %h required=r%0d %h", bus.rf_src,
                        bus.rf_waddr, bus.rf_wdata, mon_e.addr, mon_e.data);
            end
            rf_model[bus.rf_waddr] = bus.rf_wdata;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      q0.delete();
      q1.delete();
      bus.s0_valid = 1'b0;
      bus.s1_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 30 && (q0.size() + q1.size()) != 0; i++) @(posedge clk);
      #1;
      chk(name, 64'(q0.size() + q1.size()), 64'd0);
   endtask

   // Both sources offer n entries each, holding valid until accepted.
   task automatic stream(input int n);
      int i0 = 0;
      int i1 = 0;
      bit r0, r1;
      bit saw_full = 1'b0;
      for (int cyc = 0; cyc < 60 && (i0 < n || i1 < n); cyc++) begin
         bus.s0_valid = (i0 < n);
         bus.s0_addr  = 5'(16 + i0);
         bus.s0_data  = 32'hC000_0000 + 32'(i0);
         bus.s1_valid = (i1 < n);
         bus.s1_addr  = 5'(8 + i1);
         bus.s1_data  = 32'hD000_0000 + 32'(i1);
         #1;
         r0 = bus.s0_ready;
         r1 = bus.s1_ready;
         if (!r1) saw_full = 1'b1;
         @(posedge clk);
         #1;
         if (bus.s0_valid && r0) begin q0.push_back({bus.s0_addr, bus.s0_data}); i0++; end
         if (bus.s1_valid && r1) begin q1.push_back({bus.s1_addr, bus.s1_data}); i1++; end
      end
      bus.s0_valid = 1'b0;
      bus.s1_valid = 1'b0;
      chk("s1_full_seen", 64'(saw_full), 64'd1);
      chk("stream_accepted", 64'(i0 + i1), 64'(2 * n));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4:0] t2_addr [4];
      logic       t2_src  [4];
      t2_addr = '{5'd1, 5'd4, 5'd2, 5'd5};
      t2_src  = '{1'b0, 1'b1, 1'b0, 1'b1};
      n_vec = 0;
      n_err = 0;
      for (int i = 0; i < 32; i++) rf_model[i] = 32'h0;
      rst_n = 1'b0;
      bus.s0_valid = 1'b0; bus.s0_addr = '0; bus.s0_data = '0;
      bus.s1_valid = 1'b0; bus.s1_addr = '0; bus.s1_data = '0;
      bus.hz_addr  = '0;

      // Reset state, then one s0 write with its latency.
      reset_dut();
      bus.hz_addr = 5'd3;
      #1;
      chk("rst_rf_we", 64'(bus.rf_we), 64'd0);
      chk("rst_s0_ready", 64'(bus.s0_ready), 64'd1);
      chk("rst_s1_ready", 64'(bus.s1_ready), 64'd1);
      chk("rst_hz", 64'(bus.hz_pending), 64'd0);
      bus.s0_valid = 1'b1; bus.s0_addr = 5'd3; bus.s0_data = 32'hA5A5_A5A5;
      q0.push_back({5'd3, 32'hA5A5_A5A5});
      step();
      bus.s0_valid = 1'b0;
      chk("t1_we_latency", 64'(bus.rf_we), 64'd0);
      chk("t1_hz_queued", 64'(bus.hz_pending), 64'd1);
      step();
      chk("t1_we", 64'(bus.rf_we), 64'd1);
      chk("t1_waddr", 64'(bus.rf_waddr), 64'd3);
      chk("t1_wdata", 64'(bus.rf_wdata), 64'hA5A5_A5A5);
      chk("t1_src", 64'(bus.rf_src), 64'd0);
      step();
      chk("t1_we_drop", 64'(bus.rf_we), 64'd0);
      chk("t1_hz_clear", 64'(bus.hz_pending), 64'd0);
      drain("t1_drain");

      // Two entries per source interleave 1,4,2,5.
      reset_dut();
      bus.s0_valid = 1'b1; bus.s0_addr = 5'd1; bus.s0_data = 32'h1000_0001;
      bus.s1_valid = 1'b1; bus.s1_addr = 5'd4; bus.s1_data = 32'h1000_0004;
      q0.push_back({5'd1, 32'h1000_0001});
      q1.push_back({5'd4, 32'h1000_0004});
      step();
      bus.s0_addr = 5'd2; bus.s0_data = 32'h1000_0002;
      bus.s1_addr = 5'd5; bus.s1_data = 32'h1000_0005;
      q0.push_back({5'd2, 32'h1000_0002});
      q1.push_back({5'd5, 32'h1000_0005});
      step();
      bus.s0_valid = 1'b0;
      bus.s1_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) step();
         chk($sformatf("t2_waddr%0d", i), 64'(bus.rf_waddr), 64'(t2_addr[i]));
         chk($sformatf("t2_src%0d", i), 64'(bus.rf_src), 64'(t2_src[i]));
      end
      drain("t2_drain");

      // Write to r0: popped, never strobed, hazard lookup on r0 stays low.
      bus.hz_addr = 5'd0;
      bus.s0_valid = 1'b1; bus.s0_addr = 5'd0; bus.s0_data = 32'hFFFF_FFFF;
      step();
      bus.s0_valid = 1'b0;
      chk("t3_hz_r0", 64'(bus.hz_pending), 64'd0);
      step();
      chk("t3_we", 64'(bus.rf_we), 64'd0);
      chk("t3_waddr", 64'(bus.rf_waddr), 64'd0);
      chk("t3_wdata_popped", 64'(bus.rf_wdata), 64'hFFFF_FFFF);
      step();
      chk("t3_we_after", 64'(bus.rf_we), 64'd0);
      chk("t3_r0_reads_0", 64'(rf_model[0]), 64'd0);

      // Sustained traffic on both sources fills s1; nothing lost or duplicated.
      reset_dut();
      stream(6);
      drain("t4_drain");

      // Hazard on a queued load to r7.
      reset_dut();
      bus.hz_addr = 5'd7;
      bus.s1_valid = 1'b1; bus.s1_addr = 5'd7; bus.s1_data = 32'h0000_0777;
      q1.push_back({5'd7, 32'h0000_0777});
      #1;
      chk("t5_hz_push_excluded", 64'(bus.hz_pending), 64'd0);
      step();
      bus.s1_valid = 1'b0;
      chk("t5_hz_fifo", 64'(bus.hz_pending), 64'd1);
      step();
      chk("t5_hz_inflight", 64'(bus.hz_pending), 64'd1);
      chk("t5_we", 64'(bus.rf_we), 64'd1);
      step();
      chk("t5_hz_done", 64'(bus.hz_pending), 64'd0);
      drain("t5_drain");

      // Reset mid-stream.
      bus.s0_valid = 1'b1; bus.s0_addr = 5'd20; bus.s0_data = 32'h0000_0020;
      bus.s1_valid = 1'b1; bus.s1_addr = 5'd21; bus.s1_data = 32'h0000_0021;
      q0.push_back({5'd20, 32'h0000_0020});
      q1.push_back({5'd21, 32'h0000_0021});
      step();
      bus.s0_addr = 5'd22; bus.s0_data = 32'h0000_0022;
      bus.s1_addr = 5'd23; bus.s1_data = 32'h0000_0023;
      q0.push_back({5'd22, 32'h0000_0022});
      q1.push_back({5'd23, 32'h0000_0023});
      step();
      bus.s0_valid = 1'b0;
      bus.s1_valid = 1'b0;
      chk("t6_we_before_rst", 64'(bus.rf_we), 64'd1);
      rst_n = 1'b0;
      q0.delete();
      q1.delete();
      #1;
      chk("t6_we_async", 64'(bus.rf_we), 64'd0);
      chk("t6_waddr_async", 64'(bus.rf_waddr), 64'd0);
      chk("t6_wdata_async", 64'(bus.rf_wdata), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      bus.hz_addr = 5'd23;
      #1;
      chk("t6_s0_ready", 64'(bus.s0_ready), 64'd1);
      chk("t6_s1_ready", 64'(bus.s1_ready), 64'd1);
      chk("t6_hz_discarded", 64'(bus.hz_pending), 64'd0);
      bus.s0_valid = 1'b1; bus.s0_addr = 5'd11; bus.s0_data = 32'h0000_0011;
      bus.s1_valid = 1'b1; bus.s1_addr = 5'd12; bus.s1_data = 32'h0000_0012;
      q0.push_back({5'd11, 32'h0000_0011});
      q1.push_back({5'd12, 32'h0000_0012});
      step();
      bus.s0_valid = 1'b0;
      bus.s1_valid = 1'b0;
      step();
      chk("t6_tie_src", 64'(bus.rf_src), 64'd0);
      chk("t6_tie_waddr", 64'(bus.rf_waddr), 64'd11);
      step();
      chk("t6_second_src", 64'(bus.rf_src), 64'd1);
      drain("t6_drain");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
